// File: rtl/return_address_stack.sv
// Hardware call/return stack feeding the program counter.
// Calls save the current counter value; returns pulse load with the saved address one cycle later.
module return_address_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] counter,
  output logic             load,
  output logic [WIDTH-1:0] address,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   depth,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] push_idx;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             pop_ok;
  logic             grow;
  logic             shrink;
  logic             wr_en;

  assign depth = count;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Low pointer bits wrap to 0 when full, so top_idx still lands on DEPTH-1.
  assign push_idx = count[PTR_W-1:0];
  assign top_idx  = push_idx - PTR_W'(1);

  // Simultaneous call+ret is pop-then-push: the top entry is overwritten in place.
  assign pop_ok = ret && !empty;
  assign grow   = call && !pop_ok && !full;
  assign shrink = pop_ok && !call;
  assign wr_en  = call && (pop_ok || !full);
  assign wr_idx = pop_ok ? top_idx : push_idx;

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wr_idx] <= counter;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      load      <= 1'b0;
      address   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      load <= pop_ok;
      if (pop_ok) begin
        address <= mem[top_idx];
      end
      if (grow) begin
        count <= count + (PTR_W+1)'(1);
      end else if (shrink) begin
        count <= count - (PTR_W+1)'(1);
      end
      if (call && full && !pop_ok) begin
        overflow <= 1'b1;
      end
      if (ret && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: queue-based reference model,
// per-cycle comparison, directed scenarios plus randomized traffic.
module tb_return_address_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             call = 1'b0;
  logic             ret = 1'b0;
  logic [WIDTH-1:0] counter = '0;
  logic             load;
  logic [WIDTH-1:0] address;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   depth;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [WIDTH-1:0] stk [$];
  logic             exp_load = 1'b0;
  logic [WIDTH-1:0] exp_addr = '0;
  logic             exp_ovf = 1'b0;
  logic             exp_unf = 1'b0;
  bit               model_ok = 1'b0;

  return_address_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk),
    .reset(reset),
    .call(call),
    .ret(ret),
    .counter(counter),
    .load(load),
    .address(address),
    .full(full),
    .empty(empty),
    .depth(depth),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Model: ret pops first (if anything to pop), then call pushes if room remains.
  always @(posedge clk) begin
    if (!reset) begin
      stk.delete();
      exp_load = 1'b0;
      exp_addr = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      exp_load = 1'b0;
      if (ret) begin
        if (stk.size() == 0) begin
          exp_unf = 1'b1;
        end else begin
          exp_addr = stk.pop_back();
          exp_load = 1'b1;
        end
      end
      if (call) begin
        if (stk.size() == DEPTH) exp_ovf = 1'b1;
        else stk.push_back(counter);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      check("load", 32'(load), 32'(exp_load));
      check("address", 32'(address), 32'(exp_addr));
      check("depth", 32'(depth), 32'(stk.size()));
      check("full", 32'(full), 32'(stk.size() == DEPTH));
      check("empty", 32'(empty), 32'(stk.size() == 0));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("underflow", 32'(underflow), 32'(exp_unf));
    end
  end

  task automatic applyStimulus(input logic c, input logic r, input logic [WIDTH-1:0] cnt,
                               input logic rst_n);
    @(negedge clk);
    call    = c;
    ret     = r;
    counter = cnt;
    reset   = rst_n;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    check(name, act, req);
  endtask

  initial begin
    int pct_call;
    int pct_ret;

    applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 0, '0, 0);
    repeat (4) applyStimulus(0, 0, '0, 1);
    checkOutput("rst_load", 32'(load), 0);
    checkOutput("rst_address", 32'(address), 0);
    checkOutput("rst_depth", 32'(depth), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_flags", {30'd0, overflow, underflow}, 0);

    // Two calls then two rets
    applyStimulus(1, 0, 16'h0010, 1);
    applyStimulus(1, 0, 16'h0020, 1);
    checkOutput("d1", 32'(depth), 1);
    applyStimulus(0, 1, '0, 1);
    checkOutput("d2", 32'(depth), 2);
    applyStimulus(0, 1, '0, 1);
    checkOutput("r1_load", 32'(load), 1);
    checkOutput("r1_addr", 32'(address), 32'h0020);
    checkOutput("d3", 32'(depth), 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("r2_load", 32'(load), 1);
    checkOutput("r2_addr", 32'(address), 32'h0010);
    checkOutput("d4_empty", 32'(empty), 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("idle_load", 32'(load), 0);

    // Fill, overflow, drain
    for (int k = 0; k < 8; k++) applyStimulus(1, 0, 16'h0100 + 16'(k), 1);
    applyStimulus(1, 0, 16'h0200, 1);
    applyStimulus(0, 1, '0, 1);
    checkOutput("ovf_full", 32'(full), 1);
    checkOutput("ovf_depth", 32'(depth), 8);
    checkOutput("ovf_flag", 32'(overflow), 1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, (k < 7) ? 1'b1 : 1'b0, '0, 1);
      checkOutput("drain_load", 32'(load), 1);
      checkOutput("drain_addr", 32'(address), 32'h0107 - 32'(k));
    end
    applyStimulus(0, 0, '0, 1);
    checkOutput("drain_end_load", 32'(load), 0);
    checkOutput("drain_end_empty", 32'(empty), 1);

    // Underflow then recovery
    applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 1, '0, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("unf_load", 32'(load), 0);
    checkOutput("unf_flag", 32'(underflow), 1);
    applyStimulus(1, 0, 16'h0042, 1);
    applyStimulus(0, 1, '0, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("unf_rec_load", 32'(load), 1);
    checkOutput("unf_rec_addr", 32'(address), 32'h0042);
    checkOutput("unf_sticky", 32'(underflow), 1);

    // Simultaneous call+ret replaces the top
    applyStimulus(0, 0, '0, 0);
    applyStimulus(1, 0, 16'h0030, 1);
    applyStimulus(1, 0, 16'h0031, 1);
    applyStimulus(1, 1, 16'h0050, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("cr_load", 32'(load), 1);
    checkOutput("cr_addr", 32'(address), 32'h0031);
    checkOutput("cr_depth", 32'(depth), 2);
    applyStimulus(0, 1, '0, 1);
    applyStimulus(0, 0, '0, 1);
    checkOutput("cr_ret_addr", 32'(address), 32'h0050);

    // Reset colliding with a ret
    applyStimulus(1, 0, 16'h0001, 1);
    applyStimulus(1, 0, 16'h0002, 1);
    applyStimulus(1, 0, 16'h0003, 1);
    applyStimulus(0, 1, '0, 0);
    applyStimulus(0, 0, '0, 1);
    checkOutput("rr_load", 32'(load), 0);
    checkOutput("rr_depth", 32'(depth), 0);
    checkOutput("rr_flags", {30'd0, overflow, underflow}, 0);

    // Randomized traffic in push-heavy, pop-heavy and balanced phases
    for (int i = 0; i < 3000; i++) begin
      case ((i / 150) % 3)
        0:       begin pct_call = 75; pct_ret = 20; end
        1:       begin pct_call = 20; pct_ret = 75; end
        default: begin pct_call = 50; pct_ret = 50; end
      endcase
      applyStimulus($urandom_range(99) < pct_call, $urandom_range(99) < pct_ret,
                    WIDTH'($urandom), $urandom_range(399) != 0);
    end
    repeat (3) applyStimulus(0, 0, '0, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- Hardware call/return stack; the companion to the program counter.
- On a call it captures the program counter's current value.
- On a return it drives the program counter's load/address inputs with the saved value.
- Sits between the instruction decoder (call/ret strobes) and the program counter (consumes counter, produces load + address).

Parameters:
- WIDTH, 16, address width; matches program counter width.
- DEPTH, 8, number of stack entries; power of two, >= 2.
- PTR_W, 3, log2(DEPTH); sizes the pointer. The depth output is PTR_W+1 bits wide.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- call  input  1  push request from decoder; sampled each rising edge.
- ret  input  1  pop request from decoder; sampled each rising edge.
- counter  input  WIDTH  current program counter value.
- load  output  1  one-cycle pulse to the program counter's load input.
- address  output  WIDTH  return address to the program counter; valid while load=1.
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- depth  output  PTR_W+1  number of valid entries.
- overflow  output  1  sticky: a call was dropped because the stack was full.
- underflow  output  1  sticky: a ret was issued while the stack was empty.

Behaviour:
- Reset (reset=0 at rising edge):
  - depth=0, load=0, address=0, overflow=0, underflow=0, empty=1, full=0.
  - Storage contents are don't-care.
  - Reset overrides call/ret in the same edge and cancels any pending load pulse.
- Push (call=1, ret=0, not full): mem[depth] <= counter; depth <= depth+1.
- Pop (ret=1, call=0, not empty):
  - depth <= depth-1.
  - Next cycle: load=1 and address=mem[depth-1] (registered; 1-cycle latency, exactly one cycle wide).
- Program counter then loads address+1, so a pushed value equal to the call instruction's address returns to the following instruction.
- Idle cycle: load=0. address holds its last value (not required to be zero).
- Call while full:
  - Entry dropped; depth and contents unchanged; overflow <= 1.
  - Flag stays set until reset.
- Ret while empty:
  - No load pulse; depth stays 0; underflow <= 1.
  - Flag stays set until reset.
- call and ret in the same edge:
  - Processed as pop-then-push.
  - Not empty: load pulse with the old top next cycle; top replaced by counter; depth unchanged; allowed when full (no overflow).
  - Empty: underflow <= 1, no load; counter pushed, depth=1.
- Back-to-back rets on consecutive edges produce consecutive load pulses with successive entries (load high for two cycles, address changes each cycle).
- full, empty and depth are combinational from the registered depth; they reflect the state after the last edge.
- Pointer arithmetic never wraps. Depth saturates at DEPTH and 0 through the overflow/underflow rules above.
- Storage is a flop array or a synchronous-write, asynchronous-read RAM. The popped value is captured into the address register at the pop edge.

Test Plan:
- Reset then idle 3 cycles -> load=0, address=0, depth=0, empty=1, full=0, overflow=0, underflow=0.
- call with counter=0x0010, then call with counter=0x0020, then ret, then ret:
  - depth 1,2,1,0.
  - load pulses one cycle after each ret, with address=0x0020 then 0x0010.
  - empty=1 at end.
- 8 calls (counter=0x0100..0x0107), then a 9th call with counter=0x0200:
  - full=1, depth=8, overflow=1.
  - 8 rets return 0x0107 down to 0x0100; 0x0200 never appears.
- ret on an empty stack -> no load pulse, underflow=1 stays set.
  - A subsequent call with 0x0042 followed by ret returns 0x0042; underflow still 1 until reset.
- Stack holds {0x0030, 0x0031}; call+ret together with counter=0x0050:
  - Next cycle load=1, address=0x0031; depth stays 2.
  - Following ret returns 0x0050.
- reset=0 on the same edge as a ret with depth=3 -> no load pulse in the next cycle, depth=0, all flags 0.
